carry_lookahead_adder_16bits: RTL and testbench
===============================================

CARRY_LOOKAHEAD_ADDER_16BITS -- requirements
Module: carry_lookahead_adder_16bits

Interface
REQ-001 Parameters: none SHALL exist; operand width is fixed at 16 bits.
REQ-002 The ports SHALL be, in order:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in0  input  16  operand A, unsigned
- in1  input  16  operand B, unsigned
- carry_in  input  1  carry into bit 0
- sum  output  16  registered (in0 + in1 + carry_in) mod 2^16
- PG  output  1  registered group propagate of all 16 bits
- GG  output  1  registered group generate of all 16 bits
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.

Function
REQ-004 Per-bit terms SHALL be p[i] = in0[i] XOR in1[i] and g[i] = in0[i] AND in1[i], for i = 0..15.
REQ-005 Carries SHALL be computed by two-level lookahead, not by a ripple chain:
- four 4-bit groups, each producing its own group P and G
- a lookahead unit deriving group carries c4, c8 and c12 from carry_in and the group P/G terms
REQ-006 Within each group, carries SHALL be c[i+1] = g[i] | p[i]&c[i], fully expanded as sum-of-products over the group.
REQ-007 sum[i] SHALL equal p[i] XOR c[i].
REQ-008 PG SHALL equal the AND of p[15:0].
REQ-009 GG SHALL be true exactly when bits 15..0 generate a carry-out independent of carry_in (GG = G3 | P3G2 | P3P2G1 | P3P2P1G0).
REQ-010 The carry-out of the 16-bit add SHALL equal GG | (PG & carry_in); no dedicated carry-out port SHALL exist.
REQ-011 Latency SHALL be exactly 1 cycle: inputs sampled at rising edge N appear on sum, PG and GG after edge N.
REQ-012 A new operand set SHALL be accepted every cycle, with no handshake and no stall.
REQ-013 Overflow SHALL wrap modulo 2^16, e.g. 0xFFFF + 0x0001 -> sum 0x0000.
REQ-014 With carry_in=1 the result SHALL include the +1, e.g. 0xFFFF + 0x0000 + 1 -> 0x0000.
REQ-015 Outputs SHALL hold their value while inputs are unchanged.
REQ-016 No X SHALL propagate to the outputs after reset.

Reset
REQ-017 When rst=1 at a rising edge, sum SHALL become 0x0000, PG 0 and GG 0 after that edge, regardless of the inputs.
REQ-018 If rst and new operands are both present at the same edge, rst SHALL take priority; the first valid result appears 1 cycle after the first edge with rst=0.
REQ-019 Asserting rst during operation SHALL discard the in-flight result.

Structure
REQ-020 The combinational datapath SHALL be hierarchical:
- four instances of sub-module carry_lookahead_adder_4bits, each with ports in0[3:0], in1[3:0], carry_in, sum[3:0], PG, GG
- one lookahead carry unit, which may be inline
REQ-021 The only state SHALL be the output register stage in the top module.
REQ-022 No shared package is required; if one exists it SHALL hold only the width constant 16 and the group size 4.

Verification
REQ-023 Reset: rst=1 with in0=0x1234, in1=0x1111 -> sum=0x0000, PG=0, GG=0; after rst drops and one edge -> sum=0x2345.
REQ-024 Wrap: in0=0xFFFF, in1=0x0001, carry_in=0 -> sum=0x0000, PG=0, GG=1, one cycle later.
REQ-025 Full propagate: in0=0xAAAA, in1=0x5555, carry_in=1 -> sum=0x0000, PG=1, GG=0; with carry_in=0 -> sum=0xFFFF.
REQ-026 Back-to-back: 0x0001+0x0002, 0x7FFF+0x0001, 0x8000+0x8000 on consecutive cycles -> 0x0003, 0x8000, 0x0000 on consecutive cycles.
REQ-027 Exhaustive: all in0, in1 in 0..0xFFFF with carry_in=0, then random with carry_in=1 -> every sum equals (in0+in1+carry_in) mod 2^16 one cycle later, and carry-out per REQ-010 matches bit 16 of the full sum.

Source files
------------

// File: rtl/carry_lookahead_adder_16bits_pkg.sv
// Shared sizing for the 16-bit two-level carry lookahead adder.
package carry_lookahead_adder_16bits_pkg;
  localparam int WIDTH = 16;
  localparam int GROUP = 4;
endpackage

// File: rtl/carry_lookahead_adder_4bits.sv
// 4-bit lookahead group: fully expanded internal carries plus group P/G.
module carry_lookahead_adder_4bits
  import carry_lookahead_adder_16bits_pkg::*;
(
  input  logic [GROUP-1:0] in0,
  input  logic [GROUP-1:0] in1,
  input  logic             carry_in,
  output logic [GROUP-1:0] sum,
  output logic             PG,
  output logic             GG
);
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP-1:0] c;

  assign p = in0 ^ in1;
  assign g = in0 & in1;

  assign c[0] = carry_in;
  assign c[1] = g[0]
              | (p[0] & carry_in);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & carry_in);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_in);

  assign sum = p ^ c;
  assign PG  = &p;
  assign GG  = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/carry_lookahead_adder_16bits.sv
// 16-bit adder: four lookahead groups, a second-level carry unit,
// and one output register stage.
module carry_lookahead_adder_16bits
  import carry_lookahead_adder_16bits_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             PG,
  output logic             GG
);
  localparam int NGRP = WIDTH / GROUP;

  logic [NGRP-1:0]  gp;
  logic [NGRP-1:0]  gg;
  logic [NGRP-1:0]  gc;
  logic [WIDTH-1:0] sum_c;
  logic             pg_c;
  logic             gg_c;

  for (genvar i = 0; i < NGRP; i++) begin : g_grp
    carry_lookahead_adder_4bits u_grp (
      .in0      (in0[GROUP*i +: GROUP]),
      .in1      (in1[GROUP*i +: GROUP]),
      .carry_in (gc[i]),
      .sum      (sum_c[GROUP*i +: GROUP]),
      .PG       (gp[i]),
      .GG       (gg[i])
    );
  end

  // second-level lookahead: c4, c8, c12 straight from carry_in
  assign gc[0] = carry_in;
  assign gc[1] = gg[0]
               | (gp[0] & carry_in);
  assign gc[2] = gg[1]
               | (gp[1] & gg[0])
               | (gp[1] & gp[0] & carry_in);
  assign gc[3] = gg[2]
               | (gp[2] & gg[1])
               | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & carry_in);

  assign pg_c = &gp;
  assign gg_c = gg[3]
              | (gp[3] & gg[2])
              | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      PG  <= 1'b0;
      GG  <= 1'b0;
    end else begin
      sum <= sum_c;
      PG  <= pg_c;
      GG  <= gg_c;
    end
  end
endmodule

// File: tb/tb_carry_lookahead_adder_16bits.sv
// Self-checking bench: arithmetic reference model, per-cycle compare,
// plus literal expectations for the directed corner cases.
module tb_carry_lookahead_adder_16bits;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        carry_in;
  logic [15:0] sum;
  logic        PG;
  logic        GG;

  int checks = 0;
  int passes = 0;

  // literal expectation attached to the current input set
  logic        lit_en;
  logic [15:0] lit_sum;
  logic        lit_pg;
  logic        lit_gg;

  // model state, advanced on each rising edge
  logic        m_ok = 1'b0;
  logic [15:0] e_sum;
  logic        e_pg;
  logic        e_gg;
  logic        e_cout;
  logic        e_cin;
  logic        l_en = 1'b0;
  logic [15:0] l_sum;
  logic        l_pg;
  logic        l_gg;

  carry_lookahead_adder_16bits dut (
    .clk      (clk),
    .rst      (rst),
    .in0      (in0),
    .in1      (in1),
    .carry_in (carry_in),
    .sum      (sum),
    .PG       (PG),
    .GG       (GG)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [16:0] full;
    logic [16:0] nocin;
    full  = {1'b0, in0} + {1'b0, in1} + {16'd0, carry_in};
    nocin = {1'b0, in0} + {1'b0, in1};
    if (rst) begin
      m_ok   <= 1'b1;
      e_sum  <= 16'h0000;
      e_pg   <= 1'b0;
      e_gg   <= 1'b0;
      e_cout <= 1'b0;
      e_cin  <= 1'b0;
    end else begin
      e_sum  <= full[15:0];
      e_pg   <= ((in0 ^ in1) == 16'hFFFF);
      e_gg   <= nocin[16];
      e_cout <= full[16];
      e_cin  <= carry_in;
    end
    l_en  <= lit_en;
    l_sum <= lit_sum;
    l_pg  <= lit_pg;
    l_gg  <= lit_gg;
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_sum", sum, e_sum);
      chk("model_pg", {15'd0, PG}, {15'd0, e_pg});
      chk("model_gg", {15'd0, GG}, {15'd0, e_gg});
      chk("model_cout", {15'd0, GG | (PG & e_cin)}, {15'd0, e_cout});
    end
    if (l_en) begin
      chk("lit_sum", sum, l_sum);
      chk("lit_pg", {15'd0, PG}, {15'd0, l_pg});
      chk("lit_gg", {15'd0, GG}, {15'd0, l_gg});
    end
  end

  task automatic drive(input logic r, input logic [15:0] a,
                       input logic [15:0] b, input logic c,
                       input logic le, input logic [15:0] ls,
                       input logic lp, input logic lg);
    @(posedge clk);
    #2;
    rst      = r;
    in0      = a;
    in1      = b;
    carry_in = c;
    lit_en   = le;
    lit_sum  = ls;
    lit_pg   = lp;
    lit_gg   = lg;
  endtask

  initial begin
    rst = 1'b1; in0 = '0; in1 = '0; carry_in = 1'b0;
    lit_en = 1'b0; lit_sum = '0; lit_pg = 1'b0; lit_gg = 1'b0;
    drive(1, 16'h1234, 16'h1111, 0, 1, 16'h0000, 0, 0);
    drive(1, 16'h1234, 16'h1111, 0, 1, 16'h0000, 0, 0);
    drive(0, 16'h1234, 16'h1111, 0, 1, 16'h2345, 0, 0);
    drive(0, 16'hFFFF, 16'h0001, 0, 1, 16'h0000, 0, 1);
    drive(0, 16'hAAAA, 16'h5555, 1, 1, 16'h0000, 1, 0);
    drive(0, 16'hAAAA, 16'h5555, 0, 1, 16'hFFFF, 1, 0);
    drive(0, 16'hFFFF, 16'h0000, 1, 1, 16'h0000, 1, 0);
    drive(0, 16'h0001, 16'h0002, 0, 1, 16'h0003, 0, 0);
    drive(0, 16'h7FFF, 16'h0001, 0, 1, 16'h8000, 0, 0);
    drive(0, 16'h8000, 16'h8000, 0, 1, 16'h0000, 0, 1);
    for (int i = 0; i < 3; i++)
      drive(0, 16'h00F0, 16'h0F0F, 0, 1, 16'h0FFF, 1'b0, 1'b0);
    drive(0, 16'hFFFF, 16'hFFFF, 1, 1, 16'hFFFF, 0, 1);
    drive(1, 16'hFFFF, 16'hFFFF, 1, 1, 16'h0000, 0, 0);
    drive(0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 5 == 0) b = ~a;
      if (i % 7 == 0) b = 16'(~a + 16'd1);
      drive(($urandom_range(0, 99) == 0), a, b, 1'($urandom),
            0, 16'h0, 0, 0);
    end
    drive(0, 16'h0000, 16'h0000, 0, 0, 16'h0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
